// File: rtl/ysyx_25040101_exu_wb_skid.sv
// EXU->WBU pipeline stage: 2-entry skid buffer carrying ALU results, next PC and
// destination info, with fire-qualified RF/CSR write strobes, redirect pulse and retire counter.
module ysyx_25040101_exu_wb_skid #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pc_imm_ctrl_i,
  input  logic [XLEN-1:0]  rd_data_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             rd_wen_i,
  input  logic [XLEN-1:0]  csr_wdata_i,
  input  logic [11:0]      csr_addr_i,
  input  logic             csr_wen_i,

  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             rf_wen_o,
  output logic [4:0]       rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             csr_wen_o,
  output logic [11:0]      csr_waddr_o,
  output logic [XLEN-1:0]  csr_wdata_o,
  output logic [XLEN-1:0]  next_pc_o,
  output logic             redirect_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] next_pc;
    logic            taken;
    logic [XLEN-1:0] rd_data;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic [XLEN-1:0] csr_wdata;
    logic [11:0]     csr_addr;
    logic            csr_wen;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e          state_q;
  entry_t          head_q;
  entry_t          skid_q;
  entry_t          in_d;
  logic [CNT_W-1:0] cnt_q;
  logic            in_fire;
  logic            out_fire;

  assign in_ready_o  = rst_n & (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  // A fire coinciding with reset is discarded, so strobes are also gated by rst_n.
  assign out_fire    = rst_n & out_valid_o & out_ready_i;

  always_comb begin
    in_d           = '0;
    in_d.next_pc   = pc_imm_ctrl_i ? (pc_i + imm_i) : (pc_i + XLEN'(4));
    in_d.taken     = pc_imm_ctrl_i;
    in_d.rd_data   = rd_data_i;
    in_d.rd_addr   = rd_addr_i;
    in_d.rd_wen    = rd_wen_i;
    in_d.csr_wdata = csr_wdata_i;
    in_d.csr_addr  = csr_addr_i;
    in_d.csr_wen   = csr_wen_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (out_fire) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_q  <= in_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          case ({in_fire, out_fire})
            2'b11: head_q <= in_d;
            2'b10: begin
              skid_q  <= in_d;
              state_q <= TWO;
            end
            2'b01: state_q <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            head_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rf_wen_o     = out_fire & head_q.rd_wen & (head_q.rd_addr != 5'd0);
  assign rf_waddr_o   = head_q.rd_addr;
  assign rf_wdata_o   = head_q.rd_data;
  assign csr_wen_o    = out_fire & head_q.csr_wen;
  assign csr_waddr_o  = head_q.csr_addr;
  assign csr_wdata_o  = head_q.csr_wdata;
  assign next_pc_o    = head_q.next_pc;
  assign redirect_o   = out_fire & head_q.taken;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_ysyx_25040101_exu_wb_skid.sv
// Scoreboard bench for the EXU->WBU skid stage: directed pushes enqueue hand-computed
// expectations, a negedge monitor checks every out-fire and strobe quietness otherwise.
module tb_ysyx_25040101_exu_wb_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] pc_i = '0;
  logic [31:0] imm_i = '0;
  logic        pc_imm_ctrl_i = 1'b0;
  logic [31:0] rd_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_wen_i = 1'b0;
  logic [31:0] csr_wdata_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic        csr_wen_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        csr_wen_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] next_pc_o;
  logic        redirect_o;
  logic [31:0] retire_cnt_o;

  ysyx_25040101_exu_wb_skid #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .imm_i(imm_i), .pc_imm_ctrl_i(pc_imm_ctrl_i),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_wen_i(rd_wen_i),
    .csr_wdata_i(csr_wdata_i), .csr_addr_i(csr_addr_i), .csr_wen_i(csr_wen_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .next_pc_o(next_pc_o), .redirect_o(redirect_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] npc;
    logic        rfwen;
    logic [4:0]  rfaddr;
    logic [31:0] rfdata;
    logic        csrwen;
    logic [11:0] csraddr;
    logic [31:0] csrdata;
    logic        redir;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_cnt = '0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks each out-fire against the scoreboard head, and strobe silence otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmp("rst_strobes", {61'd0, rf_wen_o, csr_wen_o, redirect_o}, 64'd0);
        sb.delete();
        model_cnt = '0;
      end else if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          cmp("unexpected_fire", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          cmp("next_pc", {32'd0, next_pc_o}, {32'd0, e.npc});
          cmp("rf_wen", {63'd0, rf_wen_o}, {63'd0, e.rfwen});
          cmp("rf_waddr", {59'd0, rf_waddr_o}, {59'd0, e.rfaddr});
          cmp("rf_wdata", {32'd0, rf_wdata_o}, {32'd0, e.rfdata});
          cmp("csr_wen", {63'd0, csr_wen_o}, {63'd0, e.csrwen});
          cmp("csr_waddr", {52'd0, csr_waddr_o}, {52'd0, e.csraddr});
          cmp("csr_wdata", {32'd0, csr_wdata_o}, {32'd0, e.csrdata});
          cmp("redirect", {63'd0, redirect_o}, {63'd0, e.redir});
          cmp("retire_cnt", {32'd0, retire_cnt_o}, {32'd0, model_cnt});
          model_cnt = model_cnt + 32'd1;
        end
      end else begin
        cmp("idle_strobes", {61'd0, rf_wen_o, csr_wen_o, redirect_o}, 64'd0);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic taken,
                      input logic [31:0] rdd, input logic [4:0] rda, input logic rdw,
                      input logic [31:0] csrd, input logic [11:0] csra, input logic csrw,
                      input logic [31:0] exp_npc, input logic exp_rfwen);
    exp_t e;
    bit   done = 0;
    pc_i = pc; imm_i = imm; pc_imm_ctrl_i = taken;
    rd_data_i = rdd; rd_addr_i = rda; rd_wen_i = rdw;
    csr_wdata_i = csrd; csr_addr_i = csra; csr_wen_i = csrw;
    in_valid_i = 1'b1;
    e = '{npc: exp_npc, rfwen: exp_rfwen, rfaddr: rda, rfdata: rdd,
          csrwen: csrw, csraddr: csra, csrdata: csrd, redir: taken};
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        @(posedge clk);
        sb.push_back(e);
        done = 1;
      end
    end
    if (!done) cmp("push_timeout", 64'd1, 64'd0);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid_o) ok = 1;
    end
    if (!ok) cmp("drain_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // T1: reset held two cycles with input offered
    in_valid_i = 1'b1;
    @(negedge clk);
    cmp("rst_in_ready", {63'd0, in_ready_o}, 64'd0);
    cmp("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    cmp("rst_retire", {32'd0, retire_cnt_o}, 64'd0);
    cmp("rst_next_pc", {32'd0, next_pc_o}, 64'd0);
    @(negedge clk);
    cmp("rst_in_ready2", {63'd0, in_ready_o}, 64'd0);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    cmp("post_rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    @(posedge clk); #1;

    // T2: taken and not-taken branches
    out_ready_i = 1'b1;
    push(32'h8000_0000, 32'h10, 1'b1, 32'h1, 5'd1, 1'b1, 32'h0, 12'h0, 1'b0, 32'h8000_0010, 1'b1);
    push(32'h8000_0000, 32'h10, 1'b0, 32'h2, 5'd2, 1'b1, 32'h0, 12'h0, 1'b0, 32'h8000_0004, 1'b1);
    drain();
    cmp("t2_retire", {32'd0, retire_cnt_o}, 64'd2);

    // T3: backpressure, A and B fill the buffer, C waits
    out_ready_i = 1'b0;
    push(32'h100, 32'h0, 1'b0, 32'hA, 5'd10, 1'b1, 32'h0, 12'h0, 1'b0, 32'h104, 1'b1);
    push(32'h200, 32'h0, 1'b0, 32'hB, 5'd11, 1'b1, 32'h0, 12'h0, 1'b0, 32'h204, 1'b1);
    @(negedge clk);
    cmp("t3_full_ready", {63'd0, in_ready_o}, 64'd0);
    cmp("t3_out_valid", {63'd0, out_valid_o}, 64'd1);
    @(posedge clk); #1;
    fork
      push(32'h300, 32'h8, 1'b1, 32'hC, 5'd12, 1'b1, 32'h0, 12'h0, 1'b0, 32'h308, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();
    cmp("t3_retire", {32'd0, retire_cnt_o}, 64'd5);

    // T4: x0 write suppressed, x5 write issued
    push(32'h400, 32'h0, 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'h0, 12'h0, 1'b0, 32'h404, 1'b0);
    push(32'h404, 32'h0, 1'b0, 32'hDEAD_BEEF, 5'd5, 1'b1, 32'h0, 12'h0, 1'b0, 32'h408, 1'b1);
    push(32'h408, 32'h0, 1'b0, 32'h1234_5678, 5'd6, 1'b0, 32'h0, 12'h0, 1'b0, 32'h40C, 1'b0);

    // T5: PC wrap and CSR write
    push(32'hFFFF_FFFC, 32'h40, 1'b0, 32'h0, 5'd0, 1'b0, 32'hCAFE_0001, 12'h300, 1'b1, 32'h0000_0000, 1'b0);
    push(32'hFFFF_FFF0, 32'h20, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 12'h341, 1'b0, 32'h0000_0010, 1'b0);
    drain();
    cmp("t5_retire", {32'd0, retire_cnt_o}, 64'd10);

    // T6: reset while full with out_ready asserted
    out_ready_i = 1'b0;
    push(32'h500, 32'h0, 1'b1, 32'h55, 5'd7, 1'b1, 32'h1, 12'h305, 1'b1, 32'h500, 1'b1);
    push(32'h600, 32'h0, 1'b1, 32'h66, 5'd8, 1'b1, 32'h2, 12'h305, 1'b1, 32'h600, 1'b1);
    rst_n = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    cmp("t6_out_valid", {63'd0, out_valid_o}, 64'd0);
    cmp("t6_retire", {32'd0, retire_cnt_o}, 64'd0);
    cmp("t6_in_ready", {63'd0, in_ready_o}, 64'd1);
    cmp("t6_next_pc", {32'd0, next_pc_o}, 64'd0);
    @(posedge clk); #1;

    // Post-reset sanity transaction
    push(32'h700, 32'h4, 1'b1, 32'h77, 5'd9, 1'b1, 32'h0, 12'h0, 1'b0, 32'h704, 1'b1);
    drain();
    cmp("final_retire", {32'd0, retire_cnt_o}, 64'd1);
    cmp("sb_empty", {32'd0, 32'(sb.size())}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

endmodule
